// File: rtl/tpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// tpu_seq_pkg
// Shared definitions for the MAC-array tile sequencer and the MAC cells:
//   - seq_state_e          : sequencer FSM state encoding
//   - MAC_LATENCY_DEFAULT  : operand-to-accumulator latency of a MAC cell
//   - cnt_width()          : counter/index width helper (never returns 0)
// No ports (package).
// -----------------------------------------------------------------------------
package tpu_seq_pkg;

    // Cycles from operand presentation at a MAC cell to its accumulator update.
    localparam int unsigned MAC_LATENCY_DEFAULT = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    // Bits needed to hold values 0..n-1; clamped to 1 so degenerate
    // parameterisations still produce a legal vector width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : tpu_seq_pkg

// File: rtl/skew_lane_gen.sv
// -----------------------------------------------------------------------------
// skew_lane_gen
// Generates the skewed operand-feed schedule for the row/column lanes of an
// output-stationary MAC array. Lane i carries real data for feed steps
// i <= s < i + k_len, with k index s - i; otherwise it is zero padding.
// Outputs are registered, so the caller presents the NEXT step value.
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous, active-low reset
//   active_i      in   next cycle is a feed cycle
//   step_i        in   next feed step s
//   k_len_i       in   latched reduction depth
//   lane_valid_o  out  per-lane valid (registered)
//   lane_k_o      out  per-lane k index, slice i = lane i (registered)
// -----------------------------------------------------------------------------
module skew_lane_gen
    import tpu_seq_pkg::*;
#(
    parameter int unsigned ARRAY_DIM = 4,
    parameter int unsigned K_MAX     = 256
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        active_i,
    input  logic [cnt_width(K_MAX+2*ARRAY_DIM)-1:0]     step_i,
    input  logic [cnt_width(K_MAX+1)-1:0]               k_len_i,
    output logic [ARRAY_DIM-1:0]                        lane_valid_o,
    output logic [ARRAY_DIM*cnt_width(K_MAX)-1:0]       lane_k_o
);

    localparam int unsigned STEP_W = cnt_width(K_MAX + 2*ARRAY_DIM);
    localparam int unsigned LK_W   = cnt_width(K_MAX);

    logic [ARRAY_DIM-1:0]      lane_valid_d, lane_valid_q;
    logic [ARRAY_DIM*LK_W-1:0] lane_k_d, lane_k_q;
    logic [STEP_W-1:0]         rel;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; that is what keeps this from inferring latches.
    always_comb begin
        lane_valid_d = '0;
        lane_k_d     = '0;
        rel          = '0;
        if (active_i) begin
            for (int i = 0; i < ARRAY_DIM; i++) begin
                // rel is only meaningful once the lane's skew has elapsed,
                // which the first term guarantees (no underflow).
                rel = step_i - STEP_W'(i);
                if ((step_i >= STEP_W'(i)) && (rel < STEP_W'(k_len_i))) begin
                    lane_valid_d[i]            = 1'b1;
                    lane_k_d[i*LK_W +: LK_W]   = LK_W'(rel);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_valid_q <= '0;
            lane_k_q     <= '0;
        end else begin
            lane_valid_q <= lane_valid_d;
            lane_k_q     <= lane_k_d;
        end
    end

    assign lane_valid_o = lane_valid_q;
    assign lane_k_o     = lane_k_q;

endmodule : skew_lane_gen

// File: rtl/mac_array_sequencer.sv
// -----------------------------------------------------------------------------
// mac_array_sequencer
// Sequences one output-stationary tile on an ARRAY_DIM x ARRAY_DIM grid of
// pipelined MAC cells: one accumulator clear, the skewed operand feed
// (k_len + 2*(ARRAY_DIM-1) cycles), a MAC_LATENCY flush, optional row drain,
// then a one-cycle done pulse. All outputs are registered.
//
// Optional feature macro: SEQ_DRAIN_EN adds a DRAIN state and the
// drain_valid/drain_ready/drain_row handshake between FLUSH and DONE.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-low reset
//   start        in   tile start request (accepted only in IDLE)
//   k_len        in   reduction depth, latched on accept, clamped to K_MAX
//   abort        in   synchronous cancel of the running tile
//   drain_ready  in   (SEQ_DRAIN_EN) consumer accepts current drain_row
//   drain_valid  out  (SEQ_DRAIN_EN) drain_row is being presented
//   drain_row    out  (SEQ_DRAIN_EN) accumulator row being drained
//   busy         out  tile in progress (cycle after accept through DONE)
//   done         out  one-cycle completion pulse
//   mac_clear    out  global accumulator clear
//   mac_enable   out  global accumulate enable
//   lane_valid   out  lane i carries real operand data
//   lane_k       out  k index per lane (slice i), 0 when lane not valid
// -----------------------------------------------------------------------------
module mac_array_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int unsigned ARRAY_DIM   = 4,
    parameter int unsigned K_MAX       = 256,
    parameter int unsigned MAC_LATENCY = MAC_LATENCY_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [cnt_width(K_MAX+1)-1:0]           k_len,
    input  logic                                    abort,
`ifdef SEQ_DRAIN_EN
    input  logic                                    drain_ready,
    output logic                                    drain_valid,
    output logic [cnt_width(ARRAY_DIM)-1:0]         drain_row,
`endif
    output logic                                    busy,
    output logic                                    done,
    output logic                                    mac_clear,
    output logic                                    mac_enable,
    output logic [ARRAY_DIM-1:0]                    lane_valid,
    output logic [ARRAY_DIM*cnt_width(K_MAX)-1:0]   lane_k
);

    localparam int unsigned K_W        = cnt_width(K_MAX + 1);
    localparam int unsigned STEP_W     = cnt_width(K_MAX + 2*ARRAY_DIM);
    localparam int unsigned FL_W       = cnt_width(MAC_LATENCY);
    localparam int unsigned FEED_EXTRA = 2 * (ARRAY_DIM - 1);

    seq_state_e        state_q, state_d;
    logic [K_W-1:0]    k_len_q, k_len_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic              clear_d, done_d;
    logic              busy_q, done_q, mac_clear_q, mac_enable_q;
    logic [STEP_W-1:0] feed_last;

`ifdef SEQ_DRAIN_EN
    localparam int unsigned ROW_W = cnt_width(ARRAY_DIM);
    logic [ROW_W-1:0]  drain_row_q, drain_row_d;
    logic              drain_valid_q;
`endif

    // Last feed step index, T-1. Only used in FEED, where k_len_q >= 1.
    assign feed_last = STEP_W'(k_len_q) + STEP_W'(FEED_EXTRA) - STEP_W'(1);

    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        step_d  = step_q;
        flush_d = flush_q;
        clear_d = 1'b0;
        done_d  = 1'b0;
`ifdef SEQ_DRAIN_EN
        drain_row_d = drain_row_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    clear_d = 1'b1;
                    step_d  = '0;
                    k_len_d = (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;
                end
            end
            S_CLEAR: begin
                flush_d = '0;
                // A zero-depth tile has nothing to feed; accumulators stay 0.
                state_d = (k_len_q == '0) ? S_FLUSH : S_FEED;
            end
            S_FEED: begin
                if (step_q == feed_last) begin
                    state_d = S_FLUSH;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_FLUSH: begin
                // Hold enable low until the last operand has reached the
                // accumulator of cell (N-1, N-1).
                if (flush_q == FL_W'(MAC_LATENCY - 1)) begin
`ifdef SEQ_DRAIN_EN
                    state_d     = S_DRAIN;
                    drain_row_d = '0;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
`ifdef SEQ_DRAIN_EN
            S_DRAIN: begin
                if (drain_valid_q && drain_ready) begin
                    if (drain_row_q == ROW_W'(ARRAY_DIM - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        drain_row_d = drain_row_q + ROW_W'(1);
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort beats every transition outside IDLE; in IDLE start wins.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            clear_d = 1'b1;
            done_d  = 1'b0;
            step_d  = '0;
            flush_d = '0;
        end
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            k_len_q      <= '0;
            step_q       <= '0;
            flush_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mac_clear_q  <= 1'b0;
            mac_enable_q <= 1'b0;
`ifdef SEQ_DRAIN_EN
            drain_row_q   <= '0;
            drain_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            k_len_q      <= k_len_d;
            step_q       <= step_d;
            flush_q      <= flush_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= done_d;
            mac_clear_q  <= clear_d;
            mac_enable_q <= (state_d == S_FEED);
`ifdef SEQ_DRAIN_EN
            drain_row_q   <= drain_row_d;
            drain_valid_q <= (state_d == S_DRAIN);
`endif
        end
    end

    skew_lane_gen #(
        .ARRAY_DIM (ARRAY_DIM),
        .K_MAX     (K_MAX)
    ) u_skew (
        .clk          (clk),
        .reset        (reset),
        .active_i     (state_d == S_FEED),
        .step_i       (step_d),
        .k_len_i      (k_len_d),
        .lane_valid_o (lane_valid),
        .lane_k_o     (lane_k)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign mac_clear  = mac_clear_q;
    assign mac_enable = mac_enable_q;
`ifdef SEQ_DRAIN_EN
    assign drain_valid = drain_valid_q;
    assign drain_row   = drain_row_q;
`endif

endmodule : mac_array_sequencer

// File: doc/mac_array_sequencer.md
# mac_array_sequencer

- Sequences one output-stationary matrix tile on an ARRAY_DIM × ARRAY_DIM grid of pipelined MAC cells.
- Per tile it issues one accumulator clear, then drives the skewed operand-feed schedule for the row and column lanes, then waits out the MAC pipeline and signals completion.
- Sits between the tile scheduler (start/done handshake) and the array's operand-feed muxes and global MAC enable/clear.

## Interface

Parameters:
- ARRAY_DIM, 4: rows = columns of the MAC grid.
- K_MAX, 256: maximum reduction depth per tile.
- MAC_LATENCY, 3: cycles from operand presentation at a cell to its accumulator update.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  start request; accepted only in IDLE.
- k_len  in  $clog2(K_MAX+1)  reduction depth; latched on accept.
- abort  in  1  synchronous cancel of the current tile.
- busy  out  1  high from the cycle after accept until DONE is left.
- done  out  1  one-cycle completion pulse.
- mac_clear  out  1  global accumulator clear to the array.
- mac_enable  out  1  global accumulate enable to the array.
- lane_valid  out  ARRAY_DIM  lane i carries real operand data (not zero padding).
- lane_k  out  ARRAY_DIM*$clog2(K_MAX)  k index for lane i (slice i); 0 when the lane is not valid.
- drain_valid, drain_ready, drain_row: present only with SEQ_DRAIN_EN (see Configuration).

## Operation

States: IDLE → CLEAR → FEED → FLUSH → [DRAIN] → DONE → IDLE.

- **IDLE:** on start=1, latch k_len and go to CLEAR. If k_len > K_MAX, clamp it to K_MAX.
- **CLEAR:** mac_clear=1 for exactly one cycle. Go to FEED, or go straight to FLUSH when the latched k_len=0 (result is all zeros).
- **FEED:**
  - Runs for T = k_len + 2·(ARRAY_DIM−1) cycles, tracked by step counter s = 0..T−1.
  - mac_enable=1 every FEED cycle.
  - lane_valid[i] = (i ≤ s < i+k_len); when valid, lane_k slice i = s−i.
  - The row and column lanes share this one schedule; feed muxes supply 0 wherever a lane is not valid.
- **FLUSH:** mac_enable=0 for MAC_LATENCY cycles, so the last operand reaching cell (N−1,N−1) is accumulated before results are read.
- **DONE:** done=1 for one cycle, then IDLE. Accumulators keep their values until the next tile's CLEAR.
- **Abort:**
  - In any non-IDLE state: next cycle mac_clear=1 for one cycle, the state goes to IDLE, and done is not asserted.
  - Abort in IDLE is ignored.
  - Abort and start in the same IDLE cycle: start wins.
- **start outside IDLE:** ignored, not queued.
- **Outputs outside FEED:** mac_enable=0, lane_valid=0, lane_k=0.
- **Arithmetic:** the step counter is $clog2(K_MAX+2·ARRAY_DIM) bits wide and never wraps within a tile.

## Timing

- **Reset (async, active-low):** state=IDLE; busy, done, mac_clear, mac_enable, lane_valid, lane_k and drain_valid are all 0; counters are 0.
- **Outputs:** every output is registered. Nothing is combinational from inputs to outputs except drain_ready's effect on advance.
- **Cycle map:** take cycle 0 as the cycle start is sampled.
  - Cycle 1: CLEAR.
  - Cycles 2..T+1: FEED.
  - Next MAC_LATENCY cycles: FLUSH.
  - Cycle T+MAC_LATENCY+2: done (without drain).
- **Back-to-back tiles:** a new start is accepted in the cycle after DONE, since IDLE is reached then.
- **Reset mid-tile:** returns immediately to IDLE with all outputs 0. The array is assumed reset alongside.

## Configuration

SEQ_DRAIN_EN:
- **Defined:**
  - A DRAIN state sits between FLUSH and DONE.
  - drain_row (width $clog2(ARRAY_DIM)) steps 0..ARRAY_DIM−1 with drain_valid=1.
  - It advances only on cycles with drain_valid && drain_ready; drain_row holds while drain_ready=0.
  - After row ARRAY_DIM−1 is accepted, go to DONE.
  - Abort during DRAIN behaves as in any other state.
- **Undefined:** the drain ports and the DRAIN state do not exist; FLUSH goes directly to DONE.

## Structure

- **Shared package tpu_seq_pkg:**
  - the state enum;
  - a width helper function for k and step counter widths;
  - the default MAC_LATENCY constant, shared with the MAC cell.
- **Sub-module skew_lane_gen:**
  - Inputs: step count s and latched k_len.
  - Outputs: registered lane_valid and lane_k for all lanes.
  - Instantiated once; the FSM and counters stay in mac_array_sequencer.

## Test plan

All scenarios use ARRAY_DIM=4 and MAC_LATENCY=3 unless stated.

- **Basic tile:** start with k_len=8 → mac_clear in cycle 1; mac_enable in cycles 2..15 (T=14); done in cycle 19.
- **Skew:** k_len=8 → lane_valid[0] in FEED steps 0..7 and lane_valid[3] in steps 3..10; lane_k[3]=0 at step 3 and 7 at step 10.
- **Zero depth:** k_len=0 → clear in cycle 1, no mac_enable, done in cycle 5; start with k_len=300 → the tile runs with k_len clamped to 256 (T=262).
- **Abort:** abort at FEED step 5 → next cycle mac_clear=1 and mac_enable=0, then IDLE; no done; a following start is accepted normally.
- **Start ignored / back-to-back:** start held high during a tile → no restart; start in the cycle after done → accepted, CLEAR follows.
- **SEQ_DRAIN_EN:** drain_ready low for 2 cycles on row 1 → drain_row holds at 1; done one cycle after row 3 is accepted.
